// File: rtl/dmux_stream.sv
// dmux_stream: registered 1-to-CH stream demultiplexer with valid/ready
// handshaking, addressed or sweep (round-robin) routing, and a saturating
// count of words dropped for out-of-range addresses.
module dmux_stream #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CH    = 3,
    parameter int unsigned SELW  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SELW-1:0]       sel,
    input  logic [WIDTH-1:0]      in,
    output logic [CH*WIDTH-1:0]   out,
    output logic [CH-1:0]         out_valid,
    input  logic [CH-1:0]         out_ready,
    output logic                  err,
    output logic [7:0]            err_cnt,
    output logic [SELW-1:0]       ptr
);

    localparam int unsigned     CNTW     = 8;
    localparam logic [CNTW-1:0] CNT_MAX  = '1;
    localparam logic [SELW-1:0] PTR_LAST = SELW'(CH - 1);

    logic [SELW-1:0] dest;
    logic            in_range;
    logic [CH-1:0]   hit;
    logic            accept;

    // Destination decode and ready; out_ready feeds in_ready combinationally
    always_comb begin
        dest     = mode ? ptr : sel;
        in_range = (32'(dest) < CH);
        hit      = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            hit[c] = (32'(dest) == c);
        end
        // Out-of-range words are always taken so they can be dropped
        in_ready = 1'b1;
        if (in_range) begin
            in_ready = |(hit & (~out_valid | out_ready));
        end
        accept = in_valid & in_ready;
    end

    // Per-channel output registers: a write wins over a same-cycle drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= '0;
        end else begin
            for (int unsigned c = 0; c < CH; c++) begin
                if (accept && hit[c]) begin
                    out[c*WIDTH +: WIDTH] <= in;
                    out_valid[c]          <= 1'b1;
                end else if (out_ready[c]) begin
                    out_valid[c] <= 1'b0;
                end
            end
        end
    end

    // Drop reporting: one-cycle pulse plus saturating counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= accept & ~in_range;
            if (accept && !in_range && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + CNTW'(1);
            end
        end
    end

    // Sweep pointer advances only on accepted sweep-mode transfers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept && mode) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + SELW'(1);
        end
    end

endmodule

// File: tb/tb_dmux_stream.sv
// Testbench for dmux_stream: directed and randomized stimulus, with a
// per-channel expected-word queue filled on accepted transfers and drained
// by a separate monitor whenever a channel hands a word to its consumer.
module tb_dmux_stream;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CH    = 3;
    localparam int unsigned SELW  = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                mode;
    logic                in_valid;
    logic                in_ready;
    logic [SELW-1:0]     sel;
    logic [WIDTH-1:0]    din;
    logic [CH*WIDTH-1:0] out;
    logic [CH-1:0]       out_valid;
    logic [CH-1:0]       out_ready;
    logic                err;
    logic [7:0]          err_cnt;
    logic [SELW-1:0]     ptr;

    dmux_stream #(.WIDTH(WIDTH), .CH(CH), .SELW(SELW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .in        (din),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .err_cnt   (err_cnt),
        .ptr       (ptr)
    );

    always #5 clk = ~clk;

    // Reference model: words held per channel, sweep position, drop count
    logic [WIDTH-1:0] q [CH][$];
    int               m_ptr = 0;
    int               m_cnt = 0;
    bit               m_err = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Predictor: checks control outputs against the model, then records the
    // transfer that the coming edge will perform
    always @(negedge clk) begin
        if (rst_n) begin
            logic [CH-1:0] exp_ov;
            int  d;
            bit  exp_rdy;
            for (int c = 0; c < int'(CH); c++) exp_ov[c] = (q[c].size() != 0);
            d = mode ? m_ptr : int'(sel);
            exp_rdy = (d >= int'(CH)) || (q[d].size() == 0) || out_ready[d];
            chk("out_valid", 64'(out_valid), 64'(exp_ov));
            chk("in_ready",  64'(in_ready),  64'(exp_rdy));
            chk("err",       64'(err),       64'(m_err));
            chk("err_cnt",   64'(err_cnt),   64'(m_cnt));
            chk("ptr",       64'(ptr),       64'(m_ptr));
            m_err = 1'b0;
            if (in_valid && exp_rdy) begin
                if (d < int'(CH)) begin
                    q[d].push_back(din);
                    if (mode) m_ptr = (m_ptr + 1) % int'(CH);
                end else begin
                    m_err = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end
            end
        end
    end

    // Monitor: every consumer handshake must deliver the oldest expected word
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            for (int c = 0; c < int'(CH); c++) begin
                if (out_valid[c] && out_ready[c]) begin
                    if (q[c].size() == 0) begin
                        chk("unexpected_word", 64'(out[c*WIDTH +: WIDTH]), 64'hDEAD_0000_0000_0000);
                    end else begin
                        logic [WIDTH-1:0] e;
                        e = q[c].pop_front();
                        chk("out_data", 64'(out[c*WIDTH +: WIDTH]), 64'(e));
                    end
                end
            end
        end
    end

    task automatic step(input logic m, input logic v, input logic [SELW-1:0] s,
                        input logic [WIDTH-1:0] d, input logic [CH-1:0] r);
        mode = m; in_valid = v; sel = s; din = d; out_ready = r;
        @(posedge clk); #1;
    endtask

    // mm: 0 addressed, 1 sweep, 2 random mode
    task automatic rand_steps(input int n, input int mm);
        for (int i = 0; i < n; i++) begin
            step((mm == 2) ? 1'($urandom_range(0, 1)) : 1'(mm),
                 1'($urandom_range(0, 3) != 0),
                 SELW'($urandom_range(0, 3)),
                 WIDTH'($urandom),
                 CH'($urandom));
        end
    endtask

    task automatic check_reset_state();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out",       64'(out),       64'(0));
        chk("rst_ptr",       64'(ptr),       64'(0));
        chk("rst_err",       64'(err),       64'(0));
        chk("rst_err_cnt",   64'(err_cnt),   64'(0));
        chk("rst_in_ready",  64'(in_ready),  64'(1));
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; sel = '0; din = '0; out_ready = '1;
        #12;
        check_reset_state();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Addressed fan-out to each channel in turn
        step(1'b0, 1'b1, 2'd0, 16'hFFFF, 3'b111);
        step(1'b0, 1'b1, 2'd1, 16'hFFFF, 3'b111);
        step(1'b0, 1'b1, 2'd2, 16'hFFFF, 3'b111);
        step(1'b0, 1'b0, 2'd0, 16'h0000, 3'b111);

        // Back-pressure on channel 1
        step(1'b0, 1'b1, 2'd1, 16'hA5A5, 3'b101);
        step(1'b0, 1'b1, 2'd1, 16'h5A5A, 3'b101);
        step(1'b0, 1'b1, 2'd1, 16'h5A5A, 3'b101);
        chk("stall_hold", 64'(out[WIDTH +: WIDTH]), 64'hA5A5);
        step(1'b0, 1'b1, 2'd1, 16'h5A5A, 3'b111);
        step(1'b0, 1'b0, 2'd0, 16'h0000, 3'b111);

        // Out-of-range address dropped three times
        step(1'b0, 1'b1, 2'd3, 16'h1234, 3'b111);
        step(1'b0, 1'b1, 2'd3, 16'h1235, 3'b111);
        step(1'b0, 1'b1, 2'd3, 16'h1236, 3'b111);
        step(1'b0, 1'b0, 2'd0, 16'h0000, 3'b111);

        // Sweep 7 words, then stall with channel 1 blocked
        for (int i = 1; i <= 7; i++) step(1'b1, 1'b1, 2'd0, WIDTH'(i), 3'b111);
        step(1'b1, 1'b1, 2'd0, 16'h0008, 3'b101);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'd0, 16'h0009, 3'b100);
        step(1'b1, 1'b0, 2'd0, 16'h0000, 3'b111);

        // Mode switch preserves the sweep position
        step(1'b0, 1'b1, 2'd0, 16'h0A0A, 3'b111);
        step(1'b0, 1'b1, 2'd1, 16'h0B0B, 3'b111);
        step(1'b1, 1'b1, 2'd0, 16'h0C0C, 3'b111);

        rand_steps(400, 0);
        rand_steps(400, 1);
        rand_steps(400, 2);

        // Drop counter saturation
        for (int i = 0; i < 270; i++) step(1'b0, 1'b1, 2'd3, WIDTH'(i), 3'b111);
        chk("err_cnt_sat", 64'(err_cnt), 64'd255);

        // Load channels, then reset asynchronously between edges
        step(1'b0, 1'b1, 2'd0, 16'h1111, 3'b000);
        step(1'b0, 1'b1, 2'd2, 16'h2222, 3'b000);
        step(1'b1, 1'b1, 2'd0, 16'h3333, 3'b000);
        in_valid = 1'b1; mode = 1'b0; sel = 2'd1; din = 16'h4444;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        out_ready = '0;
        in_valid  = 1'b0;
        check_reset_state();
        for (int c = 0; c < int'(CH); c++) q[c].delete();
        m_ptr = 0; m_cnt = 0; m_err = 1'b0;
        @(posedge clk); #1;
        check_reset_state();
        rst_n = 1'b1;

        rand_steps(200, 2);
        step(1'b0, 1'b0, 2'd0, 16'h0000, 3'b111);
        step(1'b0, 1'b0, 2'd0, 16'h0000, 3'b111);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmux_stream.md
# dmux_stream

Parametrised, registered 1-to-CH stream demultiplexer with valid/ready handshaking on the input and on each output channel. It replaces the fixed 16-bit, 3-way combinational demux in the datapath wherever the producer and consumers must tolerate back-pressure. Two routing modes are supported: addressed (by `sel`) and sweep (internal round-robin pointer). Out-of-range addresses are counted and reported.

## Interface
- `WIDTH`, 16, data width per channel.
- `CH`, 3, number of output channels (2..16).
- `SELW`, 2, width of `sel`; must satisfy 2^SELW >= CH.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mode`  in  1  0 = addressed (route by `sel`), 1 = sweep (route by internal pointer).
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  input word will be accepted this cycle.
- `sel`  in  SELW  destination channel in addressed mode.
- `in`  in  WIDTH  input data.
- `out`  out  CH*WIDTH  channel c data at bits [c*WIDTH +: WIDTH].
- `out_valid`  out  CH  per-channel data valid.
- `out_ready`  in  CH  per-channel consumer ready.
- `err`  out  1  one-cycle pulse when an out-of-range word is dropped.
- `err_cnt`  out  8  saturating count of dropped words.
- `ptr`  out  SELW  current sweep pointer (debug/observability).

## Operation
- Each channel owns one output register (data + valid flag).
- Destination `d` = `sel` when `mode`=0, `ptr` when `mode`=1; both are sampled each cycle.
- Accept = `in_valid && in_ready`.
- `in_ready` is combinational:
  - If `d` < CH: `in_ready` = `!out_valid[d] || out_ready[d]`.
  - If `d` >= CH (addressed mode only): `in_ready` = 1.
- Accept with `d` < CH: `out[d]` <= `in` and `out_valid[d]` <= 1. A simultaneous drain of the same channel is legal, so one word per cycle per channel is sustained.
- Accept with `d` >= CH: the word is dropped and no channel is touched. `err` pulses high for one cycle. `err_cnt` increments and saturates at 255.
- Drain: when `out_valid[c] && out_ready[c]` and there is no new write to c, `out_valid[c]` <= 0. `out[c]` holds its last value and is not cleared.
- Channels not addressed are unaffected. Independent drains on several channels may occur in the same cycle.
- Sweep pointer:
  - Advances only on an accepted transfer while `mode`=1, wrapping CH-1 -> 0.
  - Holds in addressed mode and holds while stalled.
  - Changing `mode` does not reset `ptr`; the sweep resumes where it left off.
- Input data must be held stable while `in_valid`=1 and `in_ready`=0. The block does not check this rule.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - `out` = 0, `out_valid` = 0.
  - `ptr` = 0, `err` = 0, `err_cnt` = 0.
  - `in_ready` follows its combinational rule; with all channels empty it is 1.
- Latency: a word accepted at edge N is visible with `out_valid[d]`=1 after edge N.
- Throughput: 1 word/cycle whenever the destination consumer holds `out_ready` high, or a different channel is targeted each cycle.
- Stall: when the destination is full and its `out_ready`=0, `in_ready`=0 and no state changes except drains of other channels.
- `out_ready` -> `in_ready` is a combinational path and is documented for timing closure.
- `err` is registered. It is high in the cycle after the dropping edge.
- Reset asserted mid-transfer clears all state immediately; words in flight are lost and `err_cnt` returns to 0.

## Test plan
- Reset, then addressed mode, `in`=16'hFFFF, `sel`=0,1,2 on consecutive cycles, all `out_ready`=1 -> `out_valid` = 001, 010, 100 on successive cycles. Each channel shows FFFF. `in_ready` stays 1.
- `sel`=1, `out_ready[1]`=0, two words A5A5 then 5A5A -> first word is accepted. `in_ready`=0 while the second is pending. `out[1]` holds A5A5 until `out_ready[1]`=1, then 5A5A is accepted the same cycle and appears one cycle later.
- `sel`=3 (CH=3), `in_valid`=1 for 3 cycles -> `in_ready`=1, no `out_valid` change, `err` pulses each cycle, `err_cnt`=3. 260 such words -> `err_cnt`=255.
- `mode`=1, 7 words 0001..0007, all ready -> channels receive 0,1,2,0,1,2,0 in order. `ptr` ends at 1 (7 mod 3). Stall `out_ready[1]`=0 -> `ptr` holds at 1.
- Sweep to `ptr`=2, switch `mode`=0 for 2 words, then back to 1 -> next sweep word goes to channel 2.
- Assert `rst_n`=0 asynchronously between clock edges while channels hold data and `err_cnt`=5 -> `out_valid`=000, `out`=0, `err_cnt`=0, `ptr`=0 before the next edge.
